// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - registered fetch-stage program counter with priority next-PC select
// Run/step/halt control for the debug unit plus a committed-advance counter.
module pc_next_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] PC_INCR    = DATA_WIDTH'(4),
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_halt,
  input  logic                  i_branch_taken,
  input  logic                  i_jump_reg,
  input  logic                  i_jump,
  input  logic [DATA_WIDTH-1:0] i_pc_branch,
  input  logic [DATA_WIDTH-1:0] i_pc_reg,
  input  logic [DATA_WIDTH-1:0] i_pc_jump,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [DATA_WIDTH-1:0] o_pc_incr,
  output logic                  o_advance,
  output logic [1:0]            o_state,
  output logic                  o_halted,
  output logic [DATA_WIDTH-1:0] o_adv_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  localparam logic [DATA_WIDTH-1:0] LP_ONE = DATA_WIDTH'(1);

  state_t                r_state;
  logic                  r_halted;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_adv_count;

  logic [DATA_WIDTH-1:0] w_pc_incr;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  w_advance;

  assign w_pc_incr = r_pc + PC_INCR;

  // A decoded halt blocks the advance, so the PC freezes on the halt instruction.
  always_comb begin
    w_advance = 1'b0;
    case (r_state)
      S_RUN:   w_advance = ~i_stall & ~i_halt;
      S_STEP:  w_advance = i_step & ~i_stall & ~i_halt;
      default: w_advance = 1'b0;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_incr;
    if (i_branch_taken)  w_pc_next = i_pc_branch;
    else if (i_jump_reg) w_pc_next = i_pc_reg;
    else if (i_jump)     w_pc_next = i_pc_jump;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_halted    <= 1'b0;
      r_pc        <= RESET_PC;
      r_adv_count <= '0;
    end else begin
      if (w_advance) begin
        r_pc        <= w_pc_next;
        r_adv_count <= r_adv_count + LP_ONE;
      end
      // Mode is captured only on the start edge; HALTED is left only through reset.
      case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= i_step_mode ? S_STEP : S_RUN;
        end
        S_RUN, S_STEP: begin
          if (i_halt) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        default: r_state <= S_HALTED;
      endcase
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_incr   = w_pc_incr;
  assign o_advance   = w_advance;
  assign o_state     = r_state;
  assign o_halted    = r_halted;
  assign o_adv_count = r_adv_count;

endmodule

// File: tb/tb_pc_next_unit.sv
// tb/tb_pc_next_unit.sv - table-driven and directed checks for pc_next_unit
// A 32-bit instance covers control and priority; an 8-bit instance covers wrap-around.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst, start, mode, step, stall, halt, br, jr, jmp;
  logic [31:0] pc_br, pc_reg, pc_jmp;
  logic [31:0] pc, pc_incr, cnt;
  logic        adv, halted;
  logic [1:0]  state;
  logic [7:0]  pc8, pc_incr8, cnt8;
  logic        adv8, halted8;
  logic [1:0]  state8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.DATA_WIDTH(32), .PC_INCR(32'd4), .RESET_PC(32'd0)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_step_mode(mode), .i_step(step),
    .i_stall(stall), .i_halt(halt), .i_branch_taken(br), .i_jump_reg(jr), .i_jump(jmp),
    .i_pc_branch(pc_br), .i_pc_reg(pc_reg), .i_pc_jump(pc_jmp),
    .o_pc(pc), .o_pc_incr(pc_incr), .o_advance(adv), .o_state(state),
    .o_halted(halted), .o_adv_count(cnt)
  );

  pc_next_unit #(.DATA_WIDTH(8), .PC_INCR(8'd4), .RESET_PC(8'd0)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_step_mode(mode), .i_step(step),
    .i_stall(stall), .i_halt(halt), .i_branch_taken(br), .i_jump_reg(jr), .i_jump(jmp),
    .i_pc_branch(pc_br[7:0]), .i_pc_reg(pc_reg[7:0]), .i_pc_jump(pc_jmp[7:0]),
    .o_pc(pc8), .o_pc_incr(pc_incr8), .o_advance(adv8), .o_state(state8),
    .o_halted(halted8), .o_adv_count(cnt8)
  );

  typedef struct {
    logic        start, mode, step, stall, halt, br, jr, jmp;
    logic [31:0] pc_br, pc_reg, pc_jmp;
    logic        exp_adv;
    logic [31:0] exp_pc;
    logic [1:0]  exp_state;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic s, input logic st, input logic sl, input logic h,
                              input logic b, input logic r, input logic j,
                              input logic [31:0] tb, input logic [31:0] tr, input logic [31:0] tj,
                              input logic ea, input logic [31:0] ep, input logic [1:0] es,
                              input logic [31:0] ec);
    vec_t v;
    v.start = s; v.mode = 1'b0; v.step = st; v.stall = sl; v.halt = h;
    v.br = b; v.jr = r; v.jmp = j; v.pc_br = tb; v.pc_reg = tr; v.pc_jmp = tj;
    v.exp_adv = ea; v.exp_pc = ep; v.exp_state = es; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; mode = 0; step = 0; stall = 0; halt = 0;
    br = 0; jr = 0; jmp = 0; pc_br = 0; pc_reg = 0; pc_jmp = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  logic [31:0] model_pc;

  initial begin
    rst = 1;
    idle_inputs();
    do_reset();
    chk("reset_pc", pc, 32'h0);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_cnt", cnt, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("idle_pc_incr", pc_incr, 32'h4);
    chk("idle_adv", {31'd0, adv}, 32'd0);

    // start  step stall halt br jr j  tgt_br tgt_reg tgt_j  adv  pc  state cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h0,   2'b01, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1, 32'h4,   2'b01, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1, 32'h8,   2'b01, 2);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1, 32'hC,   2'b01, 3);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   1, 32'h10,  2'b01, 4);
    vecs[5]  = mk(0, 0, 0, 0, 1, 0, 1, 32'h100, 32'h0,   32'h200, 1, 32'h100, 2'b01, 5);
    vecs[6]  = mk(0, 0, 0, 0, 0, 1, 1, 32'h0,   32'h300, 32'h200, 1, 32'h300, 2'b01, 6);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0,   32'h20,  1, 32'h20,  2'b01, 7);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0, 1, 32'h0,   32'h0,   32'h500, 0, 32'h20,  2'b01, 7);
    vecs[9]  = mk(0, 0, 1, 0, 0, 0, 1, 32'h0,   32'h0,   32'h500, 0, 32'h20,  2'b01, 7);
    vecs[10] = mk(0, 0, 1, 0, 0, 0, 1, 32'h0,   32'h0,   32'h500, 0, 32'h20,  2'b01, 7);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 32'h0,   32'h0,   32'h500, 1, 32'h500, 2'b01, 8);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 32'h40,  32'h0,   32'h0,   1, 32'h40,  2'b01, 9);
    vecs[13] = mk(0, 0, 0, 1, 1, 0, 0, 32'h999, 32'h0,   32'h0,   0, 32'h40,  2'b11, 9);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,   0, 32'h40,  2'b11, 9);
    vecs[15] = mk(0, 1, 0, 0, 0, 0, 1, 32'h0,   32'h0,   32'h88,  0, 32'h40,  2'b11, 9);

    model_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      start = vecs[i].start; mode = vecs[i].mode; step = vecs[i].step;
      stall = vecs[i].stall; halt = vecs[i].halt;
      br = vecs[i].br; jr = vecs[i].jr; jmp = vecs[i].jmp;
      pc_br = vecs[i].pc_br; pc_reg = vecs[i].pc_reg; pc_jmp = vecs[i].pc_jmp;
      #1;
      chk($sformatf("v%0d_adv", i), {31'd0, adv}, {31'd0, vecs[i].exp_adv});
      chk($sformatf("v%0d_pc_incr", i), pc_incr, model_pc + 32'd4);
      tick();
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vecs[i].exp_state});
      chk($sformatf("v%0d_cnt", i), cnt, vecs[i].exp_cnt);
      model_pc = vecs[i].exp_pc;
    end
    chk("run_halted", {31'd0, halted}, 32'd1);

    // Reset out of HALTED.
    idle_inputs();
    rst = 1; br = 1; pc_br = 32'h77; start = 1;
    tick();
    rst = 0; idle_inputs();
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_state", {30'd0, state}, 32'd0);
    chk("halt_rst_cnt", cnt, 32'd0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);

    // Single-step: idle cycles, one pulse, stalled pulse dropped, held step.
    start = 1; mode = 1;
    tick();
    start = 0; mode = 0;
    chk("step_state", {30'd0, state}, 32'd2);
    for (int k = 0; k < 5; k++) tick();
    chk("step_idle_pc", pc, 32'h0);
    chk("step_idle_adv", {31'd0, adv}, 32'd0);
    step = 1;
    #1;
    chk("step_pulse_adv", {31'd0, adv}, 32'd1);
    tick();
    step = 0;
    chk("step_pulse_pc", pc, 32'h4);
    step = 1; stall = 1;
    #1;
    chk("step_stall_adv", {31'd0, adv}, 32'd0);
    tick();
    step = 0; stall = 0;
    tick();
    tick();
    chk("step_no_replay_pc", pc, 32'h4);
    chk("step_no_replay_cnt", cnt, 32'd1);
    step = 1;
    for (int k = 0; k < 3; k++) tick();
    step = 0;
    chk("step_held_pc", pc, 32'h10);
    chk("step_held_cnt", cnt, 32'd4);
    chk("step_mode_latched", {30'd0, state}, 32'd2);

    // Halt sampled while stalled still halts; o_halted lags by one edge.
    halt = 1; stall = 1; step = 1;
    #1;
    chk("step_halt_pre", {31'd0, halted}, 32'd0);
    tick();
    idle_inputs();
    chk("step_halt_state", {30'd0, state}, 32'd3);
    chk("step_halt_halted", {31'd0, halted}, 32'd1);
    chk("step_halt_pc", pc, 32'h10);

    // Mid-run reset.
    do_reset();
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("midrun_pc", pc, 32'h8);
    rst = 1;
    tick();
    rst = 0;
    chk("midrun_rst_pc", pc, 32'h0);
    chk("midrun_rst_cnt", cnt, 32'd0);
    chk("midrun_rst_state", {30'd0, state}, 32'd0);

    // 8-bit wrap of PC and advance counter.
    do_reset();
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 63; k++) tick();
    chk("w8_pc_fc", {24'd0, pc8}, 32'hFC);
    chk("w8_incr_wrap", {24'd0, pc_incr8}, 32'h00);
    chk("w8_cnt_63", {24'd0, cnt8}, 32'd63);
    tick();
    chk("w8_pc_wrap", {24'd0, pc8}, 32'h00);
    for (int k = 0; k < 191; k++) tick();
    chk("w8_cnt_ff", {24'd0, cnt8}, 32'hFF);
    tick();
    chk("w8_cnt_wrap", {24'd0, cnt8}, 32'h00);
    chk("w8_pc_256", {24'd0, pc8}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Registered program-counter unit for the MIPS pipeline fetch stage, extending the combinational next-PC selector. It holds the PC register and chooses the next PC from branch, jump, jump-register and increment sources by fixed priority. It honours hazard stalls and provides run, single-step and halt control for the debug unit. It also counts committed PC advances.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC and all address inputs/outputs
- PC_INCR, 4, constant added to PC for sequential fetch
- RESET_PC, 0, PC value loaded on reset

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_reset  input  1  synchronous, active-high reset
- i_start  input  1  leave IDLE and begin execution
- i_step_mode  input  1  sampled with i_start: 1 = single-step mode, 0 = free run
- i_step  input  1  in STEP state, one-cycle pulse requesting one PC advance
- i_stall  input  1  hazard stall; blocks any advance that cycle
- i_halt  input  1  halt instruction decoded at current PC
- i_branch_taken  input  1  select i_pc_branch
- i_jump_reg  input  1  select i_pc_reg
- i_jump  input  1  select i_pc_jump
- i_pc_branch  input  DATA_WIDTH  branch target
- i_pc_reg  input  DATA_WIDTH  jump-register target
- i_pc_jump  input  DATA_WIDTH  jump target
- o_pc  output  DATA_WIDTH  current PC (registered)
- o_pc_incr  output  DATA_WIDTH  o_pc + PC_INCR (combinational, modulo 2^DATA_WIDTH)
- o_advance  output  1  PC updates at the next edge (combinational)
- o_state  output  2  IDLE=00, RUN=01, STEP=10, HALTED=11
- o_halted  output  1  o_state == HALTED
- o_adv_count  output  DATA_WIDTH  number of PC advances since reset

## Operation
- Next-PC priority: i_branch_taken > i_jump_reg > i_jump > increment. Multiple asserted flags resolve by this priority with no error.
- Increment target = o_pc + PC_INCR and wraps modulo 2^DATA_WIDTH. No alignment checking.
- advance:
  - RUN: ~i_stall & ~i_halt.
  - STEP: i_step & ~i_stall & ~i_halt.
  - IDLE and HALTED: 0.
- On advance: o_pc <= selected next PC; o_adv_count <= o_adv_count + 1 (wraps).
- Without advance, o_pc and o_adv_count hold their values.
- State transitions:
  - IDLE: i_start=1 -> STEP if i_step_mode else RUN; otherwise stay.
  - RUN: i_halt=1 -> HALTED, regardless of i_stall; otherwise stay.
  - STEP: i_halt=1 -> HALTED; otherwise stay. i_step while stalled is dropped, not queued.
  - HALTED: terminal until reset.
- Mode is latched at start. i_step_mode changes after leaving IDLE have no effect.
- i_start is ignored outside IDLE.
- i_halt has priority over all select flags. The PC freezes at the halt instruction's address.

## Timing
- Reset (i_reset=1 at an edge): o_pc=RESET_PC, o_state=IDLE, o_adv_count=0, o_halted=0.
- Reset overrides all other inputs, including mid-run and HALTED.
- While in IDLE or HALTED: o_advance=0 and o_pc_incr=o_pc+PC_INCR.
- Latency: select/target inputs in cycle N appear on o_pc after edge N+1 when o_advance=1 in cycle N. One cycle total, no additional pipelining.
- The first advance happens in the cycle after the start edge. The start cycle itself is IDLE, so no advance.
- STEP: each accepted i_step pulse yields exactly one advance. An i_step held high for k unstalled cycles yields k advances.
- o_halted rises the cycle after the edge where i_halt was sampled in RUN/STEP.

## Test plan
- Reset then free run: RESET_PC=0, i_start with i_step_mode=0, no flags for 4 cycles -> o_pc = 0,4,8,12,16; o_adv_count=4.
- Priority: at PC=0x10, i_branch_taken=1 with i_pc_branch=0x100, plus i_jump=1 with i_pc_jump=0x200 -> o_pc=0x100. Next cycle, i_jump_reg=1 (0x300) with i_jump=1 -> o_pc=0x300.
- Stall: i_stall=1 for 3 cycles at PC=0x20 with i_jump=1 -> o_pc stays 0x20 and o_advance=0. First unstalled cycle -> o_pc=i_pc_jump.
- Single-step: start with i_step_mode=1; 5 idle cycles -> o_pc=0. One i_step pulse -> o_pc=4. i_step together with i_stall -> no advance, and the step is not replayed later.
- Halt and reset: in RUN at PC=0x40, i_halt=1 with i_branch_taken=1 -> o_pc stays 0x40; o_state=11 and o_halted=1 next cycle. Further i_start has no effect. i_reset -> o_pc=RESET_PC, o_state=00, o_adv_count=0.
- Wrap: DATA_WIDTH=8, PC at 0xFC, increment -> o_pc=0x00; o_adv_count wraps 0xFF->0x00.
